ram_port_arbiter: RTL

Two-port arbiter and access sequencer for the 4096 x 4-bit data RAM. It shares the single RAM port between the processor core (port 0) and a debug/loader master (port 1). Requests are granted round-robin, each granted access is held for a fixed number of RAM cycles, and completion is reported with a one-cycle acknowledge. It sits between the core's RAM address/data path and the RAM macro, and replaces the direct chip-select/write-enable drive from the decoder.

---
 rtl/ram_port_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one RAM port between the
// core (port 0) and the debug/loader master (port 1).
//
// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// ACCESS | RAM selected for the latched owner, ACCESS_CYCLES cycles
// DONE   | ack pulse to the owner, RAM deselected
module ram_port_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 4,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST_CNT = ACCESS_CYCLES[3:0];

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_ram_cs;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic                w_last_nxt;
    logic                w_owner_nxt;
    logic                w_we_nxt;
    logic                w_gnt0_nxt;
    logic                w_gnt1_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic                w_ram_cs_nxt;
    logic                w_ram_we_nxt;
    logic [ADDR_W-1:0]   w_ram_addr_nxt;
    logic [DATA_W-1:0]   w_ram_wdata_nxt;
    logic [DATA_W-1:0]   w_rdata0_nxt;
    logic [DATA_W-1:0]   w_rdata1_nxt;
    logic                w_busy_nxt;
    logic                w_pick1;

    // On a tie the port that did not win last time gets the RAM.
    assign w_pick1 = i_req1 && (!i_req0 || !r_last);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_owner_nxt     = r_owner;
        w_we_nxt        = r_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_rdata0_nxt    = r_rdata0;
        w_rdata1_nxt    = r_rdata1;

        case (r_state)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_state_nxt     = ST_ACCESS;
                    w_cnt_nxt       = 4'd1;
                    w_last_nxt      = w_pick1;
                    w_owner_nxt     = w_pick1;
                    w_we_nxt        = w_pick1 ? i_we1    : i_we0;
                    w_ram_addr_nxt  = w_pick1 ? i_addr1  : i_addr0;
                    w_ram_wdata_nxt = w_pick1 ? i_wdata1 : i_wdata0;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == LP_LAST_CNT) begin
                    w_state_nxt = ST_DONE;
                    if (!r_we) begin
                        if (r_owner) begin
                            w_rdata1_nxt = i_ram_rdata;
                        end else begin
                            w_rdata0_nxt = i_ram_rdata;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they come straight off flops.
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_gnt0_nxt   = w_busy_nxt && !w_owner_nxt;
        w_gnt1_nxt   = w_busy_nxt &&  w_owner_nxt;
        w_ack0_nxt   = (w_state_nxt == ST_DONE) && !w_owner_nxt;
        w_ack1_nxt   = (w_state_nxt == ST_DONE) &&  w_owner_nxt;
        w_ram_cs_nxt = (w_state_nxt == ST_ACCESS);
        w_ram_we_nxt = w_ram_cs_nxt && w_we_nxt;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
            r_ram_cs    <= w_ram_cs_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_rdata0    <= w_rdata0_nxt;
            r_rdata1    <= w_rdata1_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_ram_cs    = r_ram_cs;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_busy      = r_busy;

endmodule
